// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU slice: operand/opcode widths, the operand
// loader state encoding and the ALU opcode constants used by alu_8bits.
package alu_pkg;

    localparam int WIDTH = 8;
    localparam int OPW   = 2;

    // Encoding doubles as the field_idx output (next field expected).
    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_HOLD = 2'd3
    } ld_state_e;

    localparam logic [OPW-1:0] OP_ADD = 2'd0;
    localparam logic [OPW-1:0] OP_SUB = 2'd1;
    localparam logic [OPW-1:0] OP_AND = 2'd2;
    localparam logic [OPW-1:0] OP_OR  = 2'd3;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level plus a single-cycle rising-edge
// pulse taken from the synchronized level.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;

    // fill_q marks which sync stages hold a real pin sample rather than the reset
    // zero; until the last stage is real, prev_q is forced high so a line held
    // high across reset never looks like a fresh rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            fill_q <= '0;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q <= fill_q[SYNC_STAGES-1] ? sync_q[SYNC_STAGES-1] : 1'b1;
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q & fill_q[SYNC_STAGES-1];

endmodule

// File: rtl/alu_operand_loader.sv
// Serial loader for ALU operand A, operand B and opcode over one shared strobed bus.
// Optional inter-field timeout is enabled by defining OPLOAD_TIMEOUT_EN.
module alu_operand_loader #(
    parameter int WIDTH          = alu_pkg::WIDTH,
    parameter int OPW            = alu_pkg::OPW,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_strobe,
    input  logic             ld_abort,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [OPW-1:0]   op_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       field_idx,
    output logic             overrun,
    output logic             timeout_err
);
    import alu_pkg::*;

    ld_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             tmo_err_q, tmo_err_d;
    logic             strobe_rise, abort_lvl, xfer, tmo_hit;
    logic             strobe_lvl_unused, abort_rise_unused;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (ld_strobe),
        .level_o (strobe_lvl_unused),
        .rise_o  (strobe_rise)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_abort_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (ld_abort),
        .level_o (abort_lvl),
        .rise_o  (abort_rise_unused)
    );

`ifdef OPLOAD_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_wait;

    assign in_wait = (state_q == S_B) || (state_q == S_OP);
    assign tmo_hit = in_wait && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (ena) begin
            if (abort_lvl || strobe_rise || !in_wait || tmo_hit)
                cnt_d = '0;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        tmo_err_d = tmo_err_q;
        xfer      = (state_q == S_HOLD) && valid_q && out_ready;
        if (ena) begin
            // Abort wins over a same-cycle capture; a same-cycle transfer still lands.
            if (abort_lvl) begin
                state_d = S_A;
                valid_d = 1'b0;
                if (xfer) overrun_d = 1'b0;
            end else begin
                unique case (state_q)
                    S_A: if (strobe_rise) begin
                        a_d       = ld_data;
                        tmo_err_d = 1'b0;
                        state_d   = S_B;
                    end
                    S_B: if (strobe_rise) begin
                        b_d     = ld_data;
                        state_d = S_OP;
                    end else if (tmo_hit) begin
                        tmo_err_d = 1'b1;
                        state_d   = S_A;
                    end
                    S_OP: if (strobe_rise) begin
                        op_d    = ld_data[OPW-1:0];
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end else if (tmo_hit) begin
                        tmo_err_d = 1'b1;
                        state_d   = S_A;
                    end
                    S_HOLD: begin
                        if (strobe_rise) overrun_d = 1'b1;
                        if (xfer) begin
                            valid_d = 1'b0;
                            state_d = S_A;
                            if (!strobe_rise) overrun_d = 1'b0;
                        end
                    end
                    default: state_d = S_A;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign a_out       = a_q;
    assign b_out       = b_q;
    assign op_out      = op_q;
    assign out_valid   = valid_q;
    assign field_idx   = state_q;
    assign overrun     = overrun_q;
    assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Scoreboard bench for alu_operand_loader: expected operand sets are queued as the
// fields are driven and compared when the loader hands a set to the ALU.
module tb_alu_operand_loader;

    logic       clk = 1'b0;
    logic       rst_n, ena, ld_strobe, ld_abort, out_ready;
    logic [7:0] ld_data;
    logic [7:0] a_out, b_out;
    logic [1:0] op_out, field_idx;
    logic       out_valid, overrun, timeout_err;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
    } set_t;

    set_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_xfer   = 0;
    logic [1:0] idx_before, idx_after;

    always #5 clk = ~clk;

    alu_operand_loader #(
        .WIDTH(8), .OPW(2), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ld_data(ld_data),
        .ld_strobe(ld_strobe), .ld_abort(ld_abort),
        .a_out(a_out), .b_out(b_out), .op_out(op_out), .out_valid(out_valid),
        .out_ready(out_ready), .field_idx(field_idx), .overrun(overrun),
        .timeout_err(timeout_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise the strobe, record field_idx just before and just after the capture edge
    // (third clock after the rise), then release and let the line settle low.
    task automatic pulse(input logic [7:0] d);
        @(posedge clk); #1;
        ld_data   = d;
        ld_strobe = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) idx_before = field_idx;
        @(posedge clk);
        @(negedge clk) idx_after = field_idx;
        repeat (2) @(posedge clk);
        #1 ld_strobe = 1'b0;
        tick(4);
    endtask

    task automatic do_abort();
        @(posedge clk); #1 ld_abort = 1'b1;
        tick(3);
        ld_abort = 1'b0;
        tick(4);
    endtask

    always @(negedge clk) begin
        if (rst_n && ena && out_valid && out_ready) begin
            n_xfer++;
            $display("xfer %0d: a=0x%02h b=0x%02h op=%0d", n_xfer, a_out, b_out, op_out);
            check_eq("xfer_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                set_t e;
                e = sb_q.pop_front();
                check_eq("sb_a",  32'(a_out),  32'(e.a));
                check_eq("sb_b",  32'(b_out),  32'(e.b));
                check_eq("sb_op", 32'(op_out), 32'(e.op));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; ld_strobe = 1'b0; ld_abort = 1'b0;
        out_ready = 1'b0; ld_data = 8'h00;
        tick(3);
        @(negedge clk);
        check_eq("rst_a", 32'(a_out), 0);
        check_eq("rst_b", 32'(b_out), 0);
        check_eq("rst_op", 32'(op_out), 0);
        check_eq("rst_valid", 32'(out_valid), 0);
        check_eq("rst_idx", 32'(field_idx), 0);
        check_eq("rst_overrun", 32'(overrun), 0);
        check_eq("rst_tmo", 32'(timeout_err), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick(4);

        // 1) basic sequence with capture latency checks
        out_ready = 1'b1;
        sb_q.push_back('{a: 8'h3C, b: 8'hA5, op: 2'd2});
        pulse(8'h3C);
        check_eq("t1_lat_a_before", 32'(idx_before), 0);
        check_eq("t1_lat_a_after", 32'(idx_after), 1);
        check_eq("t1_a", 32'(a_out), 32'h3C);
        pulse(8'hA5);
        check_eq("t1_lat_b_before", 32'(idx_before), 1);
        check_eq("t1_lat_b_after", 32'(idx_after), 2);
        pulse(8'h02);
        check_eq("t1_lat_op_before", 32'(idx_before), 2);
        check_eq("t1_lat_op_after", 32'(idx_after), 3);
        check_eq("t1_valid_low", 32'(out_valid), 0);
        check_eq("t1_one_xfer", 32'(n_xfer), 1);

        // 2) hold with back-pressure, overrun, then transfer
        out_ready = 1'b0;
        sb_q.push_back('{a: 8'h5A, b: 8'hC3, op: 2'd3});
        pulse(8'h5A); pulse(8'hC3); pulse(8'hFF);
        tick(20);
        check_eq("t2_valid", 32'(out_valid), 1);
        check_eq("t2_idx", 32'(field_idx), 3);
        check_eq("t2_overrun0", 32'(overrun), 0);
        pulse(8'h99);
        check_eq("t2_overrun1", 32'(overrun), 1);
        check_eq("t2_a_stable", 32'(a_out), 32'h5A);
        check_eq("t2_b_stable", 32'(b_out), 32'hC3);
        check_eq("t2_op_stable", 32'(op_out), 3);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("t2_valid_after", 32'(out_valid), 0);
        check_eq("t2_overrun_clr", 32'(overrun), 0);
        check_eq("t2_idx_after", 32'(field_idx), 0);

        // 3) abort in S_B
        pulse(8'h11);
        check_eq("t3_idx_b", 32'(field_idx), 1);
        do_abort();
        check_eq("t3_idx", 32'(field_idx), 0);
        check_eq("t3_valid", 32'(out_valid), 0);
        check_eq("t3_a_kept", 32'(a_out), 32'h11);
        sb_q.push_back('{a: 8'h22, b: 8'h33, op: 2'd1});
        pulse(8'h22); pulse(8'h33); pulse(8'h01);

        // 4) edge during ena=0 is discarded
        sb_q.push_back('{a: 8'h44, b: 8'h66, op: 2'd3});
        pulse(8'h44);
        ena = 1'b0;
        pulse(8'h55);
        ena = 1'b1;
        tick(1);
        check_eq("t4_idx_frozen", 32'(field_idx), 1);
        check_eq("t4_b_kept", 32'(b_out), 32'h33);
        pulse(8'h66);
        check_eq("t4_b", 32'(b_out), 32'h66);
        check_eq("t4_idx", 32'(field_idx), 2);
        pulse(8'h03);

        // 5) inter-field timeout
        pulse(8'h77);
        tick(20);
`ifdef OPLOAD_TIMEOUT_EN
        check_eq("t5_idx", 32'(field_idx), 0);
        check_eq("t5_tmo", 32'(timeout_err), 1);
        pulse(8'h78);
        check_eq("t5_tmo_clr", 32'(timeout_err), 0);
        check_eq("t5_idx_b", 32'(field_idx), 1);
`else
        check_eq("t5_idx", 32'(field_idx), 1);
        check_eq("t5_tmo", 32'(timeout_err), 0);
`endif
        do_abort();
        check_eq("t5_idx_abort", 32'(field_idx), 0);

        // 6) reset while holding, strobe held high through reset
        out_ready = 1'b0;
        pulse(8'hE1); pulse(8'hE2); pulse(8'hE3);
        check_eq("t6_valid", 32'(out_valid), 1);
        @(posedge clk); #1 ld_strobe = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("t6_a", 32'(a_out), 0);
        check_eq("t6_b", 32'(b_out), 0);
        check_eq("t6_op", 32'(op_out), 0);
        check_eq("t6_valid0", 32'(out_valid), 0);
        check_eq("t6_idx", 32'(field_idx), 0);
        check_eq("t6_overrun", 32'(overrun), 0);
        tick(10);
        check_eq("t6_no_capture_idx", 32'(field_idx), 0);
        check_eq("t6_no_capture_a", 32'(a_out), 0);
        ld_strobe = 1'b0;
        tick(5);
        out_ready = 1'b1;
        sb_q.push_back('{a: 8'h81, b: 8'h42, op: 2'd1});
        pulse(8'h81); pulse(8'h42); pulse(8'h01);

        tick(5);
        check_eq("sb_drained", 32'(sb_q.size()), 0);
        check_eq("xfer_count", 32'(n_xfer), 5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
